imem_fetch_sequencer: RTL and testbench
=======================================

// Module: imem_fetch_sequencer
// PURPOSE
// Owns the single instruction-memory port and sequences instruction fetch for the 5-stage pipe.
// Arbitrates the port between a program loader (fills memory before a run) and the fetch PC.
// Produces a registered IF/ID instruction with valid, and honours stall, redirect (branch) and halt.
// Sits between the instruction memory (combinational read, synchronous write) and the IF/ID register.
// PARAMETERS
// ADDR_W     16       width of PC / memory address (word index)
// INSTR_W    16       instruction width
// DEPTH      128      memory words; PC wraps modulo DEPTH (power of two)
// RESET_PC   0        PC value on reset and on each start
// PORTS
// clk            in   1        single clock, rising edge
// rst            in   1        synchronous, active-high reset
// start          in   1        IDLE->RUN request (1-cycle pulse)
// halt           in   1        RUN->IDLE request
// stall          in   1        hazard unit: hold PC and IF/ID outputs
// redirect_valid in   1        taken branch from EX; load PC, squash current fetch
// redirect_pc    in   ADDR_W   branch target (word index)
// loader_req     in   1        loader wants the port (honoured only in IDLE/LOAD)
// loader_we      in   1        write strobe, valid only while in LOAD
// loader_addr    in   ADDR_W   loader word address
// loader_data    in   INSTR_W  loader write data
// mem_addr       out  ADDR_W   memory address (combinational mux)
// mem_we         out  1        memory write enable
// mem_wdata      out  INSTR_W  memory write data
// mem_rdata      in   INSTR_W  memory read data, same-cycle as mem_addr
// if_pc          out  ADDR_W   PC of if_instr
// if_instr       out  INSTR_W  fetched instruction (NOP when invalid)
// if_valid       out  1        if_instr is a live instruction
// busy           out  1        state != IDLE
// load_err       out  1        1-cycle pulse: loader_req/we seen while RUN
// fetch_count    out  16       valid fetches since start, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset: state=IDLE, pc=RESET_PC, if_pc=0, if_instr=NOP(16'hBF00), if_valid=0, fetch_count=0,
//   load_err=0, mem_we=0. Reset mid-RUN or mid-LOAD aborts immediately; no write issued that cycle.
// - States IDLE, LOAD, RUN. IDLE: loader_req->LOAD (priority over start); start->RUN, pc<=RESET_PC,
//   fetch_count<=0. LOAD: loader_req=0 -> IDLE. RUN: halt -> IDLE (if_valid<=0, if_instr<=NOP).
// - Port mux: LOAD -> mem_addr=loader_addr, mem_we=loader_we, mem_wdata=loader_data;
//   else mem_addr=pc, mem_we=0, mem_wdata=0. mem_we never asserts outside LOAD.
// - RUN, priority redirect > stall > advance, per rising edge:
//   redirect: pc<=redirect_pc mod DEPTH, if_valid<=0, if_instr<=NOP (squash, even if stall=1).
//   stall: pc, if_pc, if_instr, if_valid held.
//   advance: if_instr<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=(pc+1) mod DEPTH, fetch_count++.
// - Latency: start at edge N -> first if_valid=1 after edge N+1 (if_pc=RESET_PC). After redirect at
//   edge N, target instruction valid after edge N+1 (one bubble).
// - halt and redirect same cycle: halt wins. loader_req in RUN ignored, load_err pulses one cycle.
// - pc = DEPTH-1 advances to 0; redirect_pc >= DEPTH is masked to low log2(DEPTH) bits.
// STRUCTURE
// - Shared package fetch_pkg: state encoding (IDLE/LOAD/RUN), NOP_INSTR=16'hBF00, DEPTH default.
// - One sub-module imem_pc_reg: PC register with load/hold/increment and modulo-DEPTH wrap.
// - Top: FSM, port mux, IF/ID output regs, fetch counter. Memory itself stays outside.
// TESTING
// - Load 3 words (addr 0..2 = 0x2000,0x2101,0x1840), start -> if_pc 0,1,2 valid on consecutive cycles.
// - RUN, stall high 3 cycles at if_pc=4 -> if_pc/if_instr held 3 cycles, fetch_count unchanged.
// - Redirect to 4 at if_pc=10 -> one cycle if_valid=0/if_instr=0xBF00, then if_pc=4 valid.
// - Redirect+stall same cycle -> redirect taken; pc=127 advance -> next if_pc=0 (wrap).
// - loader_req+we in RUN -> mem_we stays 0, load_err 1 cycle; halt -> busy=0 next cycle.
// - rst asserted mid-LOAD with loader_we=1 -> no write that edge, all outputs at reset values.

Source files
------------

// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    // Sequencer operating states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Instruction presented on IF/ID whenever the slot is not live
    localparam logic [15:0] NOP_INSTR = 16'hBF00;

    // Default instruction memory depth in words
    localparam int DEPTH_DEFAULT = 128;

    // Saturating increment used by the fetch counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/imem_fetch_sequencer_if.sv
// Bundle of control, loader, memory-port and IF/ID signals around the sequencer.
interface imem_fetch_sequencer_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    // Pipeline control
    logic               start;
    logic               halt;
    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    // Program loader
    logic               loader_req;
    logic               loader_we;
    logic [ADDR_W-1:0]  loader_addr;
    logic [INSTR_W-1:0] loader_data;
    // Instruction memory port
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [INSTR_W-1:0] mem_wdata;
    logic [INSTR_W-1:0] mem_rdata;
    // IF/ID and status
    logic [ADDR_W-1:0]  if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               if_valid;
    logic               busy;
    logic               load_err;
    logic [15:0]        fetch_count;

    // Sequencer side
    modport master (
        input  start, halt, stall, redirect_valid, redirect_pc,
        input  loader_req, loader_we, loader_addr, loader_data,
        input  mem_rdata,
        output mem_addr, mem_we, mem_wdata,
        output if_pc, if_instr, if_valid, busy, load_err, fetch_count
    );

    // Surrounding pipeline / memory / loader side
    modport slave (
        output start, halt, stall, redirect_valid, redirect_pc,
        output loader_req, loader_we, loader_addr, loader_data,
        output mem_rdata,
        input  mem_addr, mem_we, mem_wdata,
        input  if_pc, if_instr, if_valid, busy, load_err, fetch_count
    );

endinterface

// File: rtl/imem_fetch_sequencer_pc_reg.sv
// Program counter with load / increment / hold, always kept modulo DEPTH.
module imem_pc_reg #(
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 128,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);
    // DEPTH is a power of two, so masking is the modulo operation
    localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: load beats increment, otherwise hold
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i & PC_MASK;
        end else if (inc_i) begin
            pc_d = (pc_q + ADDR_W'(1)) & PC_MASK;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= ADDR_W'(RESET_PC) & PC_MASK;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Owns the instruction memory port: loader writes in LOAD, PC fetches in RUN,
// and produces the registered IF/ID instruction with stall/redirect/halt.
module imem_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 16,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    imem_fetch_sequencer_if.master bus
);
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

    state_e             state_q;
    state_e             state_d;

    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_val;
    logic               pc_inc;
    logic [ADDR_W-1:0]  pc;

    logic               advance;
    logic               squash;
    logic               start_run;
    logic               in_load;

    logic [ADDR_W-1:0]  if_pc_q;
    logic [INSTR_W-1:0] if_instr_q;
    logic               if_valid_q;
    logic [15:0]        fetch_count_q;
    logic               load_err_q;

    // Next state and per-cycle fetch decisions (halt > redirect > stall > advance)
    always_comb begin
        state_d     = state_q;
        pc_load     = 1'b0;
        pc_load_val = ADDR_W'(RESET_PC);
        pc_inc      = 1'b0;
        advance     = 1'b0;
        squash      = 1'b0;
        start_run   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.loader_req) begin
                    state_d = ST_LOAD;
                end else if (bus.start) begin
                    state_d   = ST_RUN;
                    start_run = 1'b1;
                    pc_load   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!bus.loader_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.halt) begin
                    state_d = ST_IDLE;
                    squash  = 1'b1;
                end else if (bus.redirect_valid) begin
                    squash      = 1'b1;
                    pc_load     = 1'b1;
                    pc_load_val = bus.redirect_pc;
                end else if (!bus.stall) begin
                    advance = 1'b1;
                    pc_inc  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    imem_pc_reg #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    // IF/ID slot, fetch counter and loader-misuse flag
    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc_q       <= '0;
            if_instr_q    <= NOP;
            if_valid_q    <= 1'b0;
            fetch_count_q <= '0;
            load_err_q    <= 1'b0;
        end else begin
            load_err_q <= (state_q == ST_RUN) && (bus.loader_req || bus.loader_we);
            if (start_run) begin
                fetch_count_q <= '0;
            end else if (advance) begin
                fetch_count_q <= sat_inc16(fetch_count_q);
            end
            if (squash) begin
                if_valid_q <= 1'b0;
                if_instr_q <= NOP;
            end else if (advance) begin
                if_instr_q <= bus.mem_rdata;
                if_pc_q    <= pc;
                if_valid_q <= 1'b1;
            end
        end
    end

    // Memory port mux; the write strobe is also killed by reset so an
    // aborted load never lands a write on the reset edge
    assign in_load       = (state_q == ST_LOAD);
    assign bus.mem_addr  = in_load ? bus.loader_addr : pc;
    assign bus.mem_we    = in_load && bus.loader_we && !rst;
    assign bus.mem_wdata = in_load ? bus.loader_data : '0;

    assign bus.if_pc       = if_pc_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.load_err    = load_err_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Randomized + directed bench for imem_fetch_sequencer with a behavioural model.
module tb_imem_fetch_sequencer;
    import fetch_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 128;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    imem_fetch_sequencer #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory stub: combinational read, synchronous write
    logic [15:0] mem [0:DEPTH-1];
    assign bus.mem_rdata = mem[bus.mem_addr[6:0]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, PC and IF/ID slot as plain integers
    int          m_mode;
    int          m_pc;
    int          m_if_pc;
    logic [15:0] m_if_instr;
    bit          m_if_valid;
    int          m_count;
    bit          m_load_err;
    logic [15:0] exp_mem [0:DEPTH-1];
    bit          armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            armed      <= 1'b1;
            m_mode     <= M_IDLE;
            m_pc       <= 0;
            m_if_pc    <= 0;
            m_if_instr <= 16'hBF00;
            m_if_valid <= 1'b0;
            m_count    <= 0;
            m_load_err <= 1'b0;
        end else begin
            m_load_err <= (m_mode == M_RUN) && (bus.loader_req || bus.loader_we);
            if (m_mode == M_IDLE) begin
                if (bus.loader_req) m_mode <= M_LOAD;
                else if (bus.start) begin
                    m_mode  <= M_RUN;
                    m_pc    <= 0;
                    m_count <= 0;
                end
            end else if (m_mode == M_LOAD) begin
                if (bus.loader_we) exp_mem[int'(bus.loader_addr) % DEPTH] <= bus.loader_data;
                if (!bus.loader_req) m_mode <= M_IDLE;
            end else begin
                if (bus.halt) begin
                    m_mode     <= M_IDLE;
                    m_if_valid <= 1'b0;
                    m_if_instr <= 16'hBF00;
                end else if (bus.redirect_valid) begin
                    m_pc       <= int'(bus.redirect_pc) % DEPTH;
                    m_if_valid <= 1'b0;
                    m_if_instr <= 16'hBF00;
                end else if (!bus.stall) begin
                    m_if_instr <= exp_mem[m_pc];
                    m_if_pc    <= m_pc;
                    m_if_valid <= 1'b1;
                    m_pc       <= (m_pc + 1) % DEPTH;
                    m_count    <= (m_count >= 65535) ? 65535 : m_count + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            chk("if_valid", 32'(bus.if_valid), 32'(m_if_valid));
            chk("if_instr", 32'(bus.if_instr), 32'(m_if_instr));
            if (m_if_valid) chk("if_pc", 32'(bus.if_pc), 32'(m_if_pc));
            chk("fetch_count", 32'(bus.fetch_count), 32'(m_count));
            chk("busy", 32'(bus.busy), 32'(m_mode != M_IDLE));
            chk("load_err", 32'(bus.load_err), 32'(m_load_err));
            chk("mem_we", 32'(bus.mem_we), 32'((m_mode == M_LOAD) && bus.loader_we && !rst));
            chk("mem_addr", 32'(bus.mem_addr),
                (m_mode == M_LOAD) ? 32'(bus.loader_addr) : 32'(m_pc));
            chk("mem_wdata", 32'(bus.mem_wdata),
                (m_mode == M_LOAD) ? 32'(bus.loader_data) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start          = 1'b0;
        bus.halt           = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.loader_req     = 1'b0;
        bus.loader_we      = 1'b0;
        bus.loader_addr    = '0;
        bus.loader_data    = '0;
    endtask

    logic [15:0] img [0:DEPTH-1];
    logic [15:0] mem7_before;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 16'h0000;
            exp_mem[i] = 16'h0000;
            img[i]     = 16'($urandom);
        end
        img[0] = 16'h2000;
        img[1] = 16'h2101;
        img[2] = 16'h1840;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_if_instr", 32'(bus.if_instr), 32'h0000BF00);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_fetch_count", 32'(bus.fetch_count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Load the whole image
        bus.loader_req = 1'b1;
        tick();
        chk("load_busy", 32'(bus.busy), 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            bus.loader_we   = 1'b1;
            bus.loader_addr = 16'(a);
            bus.loader_data = img[a];
            tick();
        end
        clear_inputs();
        tick();
        chk("load_done_idle", 32'(bus.busy), 32'd0);

        // Start: first instruction appears one edge after the start edge
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_bubble", 32'(bus.if_valid), 32'd0);
        tick();
        chk("first_pc", 32'(bus.if_pc), 32'd0);
        chk("first_instr", 32'(bus.if_instr), 32'h00002000);
        tick();
        chk("second_pc", 32'(bus.if_pc), 32'd1);
        chk("second_instr", 32'(bus.if_instr), 32'h00002101);
        tick();
        chk("third_pc", 32'(bus.if_pc), 32'd2);
        chk("third_instr", 32'(bus.if_instr), 32'h00001840);
        tick();
        tick();
        chk("pre_stall_pc", 32'(bus.if_pc), 32'd4);

        // Stall for three edges at if_pc = 4
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", 32'(bus.if_pc), 32'd4);
            chk("stall_instr", 32'(bus.if_instr), 32'(img[4]));
            chk("stall_count", 32'(bus.fetch_count), 32'd5);
        end
        bus.stall = 1'b0;

        // Run up to if_pc = 10, then redirect to 4
        begin
            int guard = 0;
            while (!(bus.if_valid && bus.if_pc == 16'd10) && guard < 50) begin
                tick();
                guard++;
            end
            chk("reach_pc10_timeout", 32'(guard < 50), 32'd1);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'd4;
        tick();
        bus.redirect_valid = 1'b0;
        chk("redir_bubble_valid", 32'(bus.if_valid), 32'd0);
        chk("redir_bubble_instr", 32'(bus.if_instr), 32'h0000BF00);
        tick();
        chk("redir_target_pc", 32'(bus.if_pc), 32'd4);
        chk("redir_target_valid", 32'(bus.if_valid), 32'd1);

        // Redirect together with stall, target beyond DEPTH to 127, then wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h00FF;
        bus.stall          = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        chk("redir_stall_squash", 32'(bus.if_valid), 32'd0);
        tick();
        chk("pc127", 32'(bus.if_pc), 32'd127);
        tick();
        chk("wrap_pc0", 32'(bus.if_pc), 32'd0);
        chk("wrap_instr", 32'(bus.if_instr), 32'h00002000);

        // Loader poking the port while running
        bus.loader_req  = 1'b1;
        bus.loader_we   = 1'b1;
        bus.loader_addr = 16'd5;
        bus.loader_data = 16'h1234;
        #1;
        chk("run_no_we", 32'(bus.mem_we), 32'd0);
        tick();
        clear_inputs();
        chk("load_err_pulse", 32'(bus.load_err), 32'd1);
        tick();
        chk("load_err_clear", 32'(bus.load_err), 32'd0);

        // Halt
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk("halt_busy", 32'(bus.busy), 32'd0);
        chk("halt_valid", 32'(bus.if_valid), 32'd0);

        // Randomized operation
        for (int c = 0; c < 1500; c++) begin
            clear_inputs();
            bus.loader_addr = 16'($urandom_range(0, DEPTH - 1));
            bus.loader_data = 16'($urandom);
            bus.loader_we   = ($urandom_range(0, 99) < 10);
            if (m_mode == M_IDLE) begin
                int r = $urandom_range(0, 99);
                if (r < 5) bus.loader_req = 1'b1;
                else if (r < 40) bus.start = 1'b1;
                bus.stall = $urandom_range(0, 1) == 1;
            end else if (m_mode == M_LOAD) begin
                bus.loader_req = ($urandom_range(0, 99) < 85);
                bus.loader_we  = $urandom_range(0, 1) == 1;
            end else begin
                bus.stall          = ($urandom_range(0, 99) < 25);
                bus.redirect_valid = ($urandom_range(0, 99) < 8);
                bus.redirect_pc    = 16'($urandom_range(0, 255));
                bus.halt           = ($urandom_range(0, 99) < 2);
                bus.loader_req     = ($urandom_range(0, 99) < 3);
                bus.loader_we      = ($urandom_range(0, 99) < 3);
                bus.start          = ($urandom_range(0, 99) < 5);
            end
            tick();
        end

        // Reset while loading with a write strobe up
        clear_inputs();
        tick();
        bus.loader_req = 1'b1;
        tick();
        chk("pre_rst_in_load", 32'(bus.busy), 32'd1);
        mem7_before     = mem[7];
        bus.loader_we   = 1'b1;
        bus.loader_addr = 16'd7;
        bus.loader_data = ~mem7_before;
        rst = 1'b1;
        #1;
        chk("rst_we_gated", 32'(bus.mem_we), 32'd0);
        tick();
        chk("rst_no_write", 32'(mem[7]), 32'(mem7_before));
        chk("rst_busy_load", 32'(bus.busy), 32'd0);
        chk("rst_valid_load", 32'(bus.if_valid), 32'd0);
        chk("rst_instr_load", 32'(bus.if_instr), 32'h0000BF00);
        chk("rst_pc_load", 32'(bus.if_pc), 32'd0);
        chk("rst_count_load", 32'(bus.fetch_count), 32'd0);
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
